itu656_tx_framer: RTL and testbench

//  Transmit side of the ITU-R BT.656 link: turns a 16-bit YCbCr 4:2:2 pixel stream
//  (SDRAM frame-buffer read FIFO) into a 27 MHz 8-bit 525/60 BT.656 byte stream with
//  EAV/SAV timing codes, blanking fill and F/V flags. Feeds a video encoder or GPIO loopback.

---
 rtl/itu656_pkg.sv | 52 +++++
 rtl/itu656_timing.sv | 94 +++++++++
 rtl/itu656_tx_framer.sv | 117 +++++++++++
 tb/tb_itu656_tx_framer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/itu656_pkg.sv
// itu656_pkg
//   Shared definitions for the BT.656 transmit framer and anything that checks
//   its output: 525/60 default timing constants, counter widths, the timing
//   reference preamble and blanking bytes, the horizontal region type, and
//   helpers for the XY status word and the pixel data clamp.
package itu656_pkg;

  // 525/60 defaults, also handy for a decoder-side checker.
  localparam int H_TOTAL_525  = 1716;
  localparam int H_ACTIVE_525 = 1440;
  localparam int V_TOTAL_525  = 525;
  localparam int V1_END_525   = 19;
  localparam int V2_START_525 = 264;
  localparam int V2_END_525   = 282;
  localparam int F0_START_525 = 4;
  localparam int F1_START_525 = 266;

  localparam int HCNT_W = 11;
  localparam int LINE_W = 10;

  localparam logic [7:0] PREAMBLE_FF = 8'hFF;
  localparam logic [7:0] PREAMBLE_00 = 8'h00;
  localparam logic [7:0] BLANK_EVEN  = 8'h80;
  localparam logic [7:0] BLANK_ODD   = 8'h10;

  // Where the byte counter sits within a line. ACTIVE is only reported on
  // lines that carry picture; active-window bytes of vertical blanking lines
  // are reported as BLANK.
  typedef enum logic [1:0] {
    REG_EAV,
    REG_BLANK,
    REG_SAV,
    REG_ACTIVE
  } h_region_e;

  // Fourth byte of EAV/SAV: fixed 1, F, V, H, then the protection bits.
  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // 00 and FF only ever appear inside timing reference codes.
  function automatic logic [7:0] clamp_pixel(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

  function automatic logic [7:0] blank_byte(input logic odd);
    return odd ? BLANK_ODD : BLANK_EVEN;
  endfunction

endpackage

// File: rtl/itu656_timing.sv
// itu656_timing
//   Byte and line counters for the BT.656 framer plus everything decoded from
//   them.
//   Ports:
//     clk, rst      byte clock, synchronous active-high reset
//     en            run enable; counters hold while low
//     line          current line number 1..V_TOTAL
//     f, v          field and vertical-blank flags of the current line
//     region        EAV / blank / SAV / active (active only on picture lines)
//     code_pos      byte index 0..3 inside EAV or SAV
//     odd           low bit of the byte counter, selects 80/10 and C/Y
//     request       pixel FIFO read strobe, two bytes ahead of each C/Y pair
//     frame_start   registered pulse alongside the first EAV byte of line 1
module itu656_timing
  import itu656_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_525,
  parameter int H_ACTIVE = H_ACTIVE_525,
  parameter int V_TOTAL  = V_TOTAL_525,
  parameter int V1_END   = V1_END_525,
  parameter int V2_START = V2_START_525,
  parameter int V2_END   = V2_END_525,
  parameter int F0_START = F0_START_525,
  parameter int F1_START = F1_START_525
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LINE_W-1:0] line,
  output logic              f,
  output logic              v,
  output h_region_e         region,
  output logic [1:0]        code_pos,
  output logic              odd,
  output logic              request,
  output logic              frame_start
);

  localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] EAV_END   = HCNT_W'(4);
  localparam logic [HCNT_W-1:0] SAV_START = HCNT_W'(H_TOTAL - H_ACTIVE - 4);
  localparam logic [HCNT_W-1:0] ACT_START = HCNT_W'(H_TOTAL - H_ACTIVE);
  localparam logic [HCNT_W-1:0] REQ_FIRST = HCNT_W'(H_TOTAL - H_ACTIVE - 2);
  localparam logic [HCNT_W-1:0] REQ_LAST  = HCNT_W'(H_TOTAL - 4);
  localparam logic [LINE_W-1:0] L_LAST    = LINE_W'(V_TOTAL);
  localparam logic [LINE_W-1:0] L_V1_END  = LINE_W'(V1_END);
  localparam logic [LINE_W-1:0] L_V2_BEG  = LINE_W'(V2_START);
  localparam logic [LINE_W-1:0] L_V2_END  = LINE_W'(V2_END);
  localparam logic [LINE_W-1:0] L_F0_BEG  = LINE_W'(F0_START);
  localparam logic [LINE_W-1:0] L_F1_BEG  = LINE_W'(F1_START);

  logic [HCNT_W-1:0] hcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      line        <= LINE_W'(1);
      frame_start <= 1'b0;
    end else begin
      frame_start <= en && (hcnt == '0) && (line == LINE_W'(1));
      if (en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          line <= (line == L_LAST) ? LINE_W'(1) : line + LINE_W'(1);
        end else begin
          hcnt <= hcnt + HCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    f   = (line >= L_F1_BEG) || (line < L_F0_BEG);
    v   = (line <= L_V1_END) || ((line >= L_V2_BEG) && (line <= L_V2_END));
    odd = hcnt[0];

    region   = REG_BLANK;
    code_pos = hcnt[1:0];
    if (hcnt < EAV_END) begin
      region = REG_EAV;
    end else if ((hcnt >= SAV_START) && (hcnt < ACT_START)) begin
      region   = REG_SAV;
      // Modulo-4 offset from the SAV start, so SAV need not be 4-aligned.
      code_pos = hcnt[1:0] - SAV_START[1:0];
    end else if ((hcnt >= ACT_START) && !v) begin
      region = REG_ACTIVE;
    end

    // Even counts only: each request fetches the word for the pair starting
    // two bytes later. Reset is folded in so the strobe drops immediately.
    request = en && !rst && !v && !hcnt[0] && (hcnt >= REQ_FIRST) && (hcnt <= REQ_LAST);
  end

endmodule

// File: rtl/itu656_tx_framer.sv
// itu656_tx_framer
//   BT.656 transmitter: turns a 16-bit 4:2:2 word stream from the frame-buffer
//   read FIFO into the 8-bit 27 MHz byte stream with EAV/SAV codes and 80/10
//   blanking fill.
//   Ports:
//     iCLK_27       byte clock
//     iRST          synchronous active-high reset
//     iEN           run enable; low freezes position and sends 80/10 fill
//     iYCbCr        [15:8] Y, [7:0] Cb or Cr, in the order the FIFO holds them
//     iDVAL         word valid, captured the cycle after oRequest
//     oRequest      one-word FIFO read strobe
//     oTD_DATA      registered BT.656 byte
//     oLINE         current line 1..V_TOTAL
//     oFIELD        current F bit
//     oFRAME_START  pulse alongside the first EAV byte of line 1
//     oUNDERFLOW    sticky: a needed word arrived without iDVAL
module itu656_tx_framer
  import itu656_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_525,
  parameter int H_ACTIVE = H_ACTIVE_525,
  parameter int V_TOTAL  = V_TOTAL_525,
  parameter int V1_END   = V1_END_525,
  parameter int V2_START = V2_START_525,
  parameter int V2_END   = V2_END_525,
  parameter int F0_START = F0_START_525,
  parameter int F1_START = F1_START_525
) (
  input  logic              iCLK_27,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [15:0]       iYCbCr,
  input  logic              iDVAL,
  output logic              oRequest,
  output logic [7:0]        oTD_DATA,
  output logic [LINE_W-1:0] oLINE,
  output logic              oFIELD,
  output logic              oFRAME_START,
  output logic              oUNDERFLOW
);

  logic [LINE_W-1:0] line;
  logic              f, v, odd, request, frame_start;
  h_region_e         region;
  logic [1:0]        code_pos;

  logic       req_d, sample_ok, underflow, fill_odd;
  logic [7:0] sample_y, sample_c, next_byte, td;

  itu656_timing #(
    .H_TOTAL (H_TOTAL),  .H_ACTIVE(H_ACTIVE), .V_TOTAL (V_TOTAL),
    .V1_END  (V1_END),   .V2_START(V2_START), .V2_END  (V2_END),
    .F0_START(F0_START), .F1_START(F1_START)
  ) u_timing (
    .clk(iCLK_27), .rst(iRST), .en(iEN),
    .line(line), .f(f), .v(v), .region(region), .code_pos(code_pos),
    .odd(odd), .request(request), .frame_start(frame_start)
  );

  // The FIFO answers one cycle after the strobe, so capture follows the
  // delayed strobe rather than the counter; a word requested just before iEN
  // drops is still caught and replayed when the line resumes. The Cb/Cr
  // alternation is carried by the FIFO word order, so no local phase is kept.
  always_ff @(posedge iCLK_27) begin
    if (iRST) begin
      req_d     <= 1'b0;
      sample_ok <= 1'b0;
      sample_y  <= 8'h00;
      sample_c  <= 8'h00;
      underflow <= 1'b0;
      fill_odd  <= 1'b0;
      td        <= BLANK_ODD;
    end else begin
      req_d <= request;
      if (req_d) begin
        sample_y  <= iYCbCr[15:8];
        sample_c  <= iYCbCr[7:0];
        sample_ok <= iDVAL;
        if (!iDVAL) underflow <= 1'b1;
      end
      // While paused the counter is frozen, so fill parity runs on its own
      // toggle, restarting at 80 on every pause.
      fill_odd <= iEN ? 1'b0 : ~fill_odd;
      td       <= next_byte;
    end
  end

  // Pair starts fall on even counts, so the low count bit picks C then Y.
  always_comb begin
    next_byte = blank_byte(odd);
    if (!iEN) begin
      next_byte = blank_byte(fill_odd);
    end else begin
      case (region)
        REG_EAV, REG_SAV: begin
          case (code_pos)
            2'd0:    next_byte = PREAMBLE_FF;
            2'd3:    next_byte = xy_code(f, v, region == REG_EAV);
            default: next_byte = PREAMBLE_00;
          endcase
        end
        REG_ACTIVE: begin
          if (sample_ok) next_byte = clamp_pixel(odd ? sample_y : sample_c);
        end
        default: next_byte = blank_byte(odd);
      endcase
    end
  end

  assign oRequest     = request;
  assign oTD_DATA     = td;
  assign oLINE        = line;
  assign oFIELD       = f;
  assign oFRAME_START = frame_start;
  assign oUNDERFLOW   = underflow;

endmodule

// File: tb/tb_itu656_tx_framer.sv
// tb_itu656_tx_framer
//   Directed bench for itu656_tx_framer. Full 1716-byte lines, with a short
//   10-line frame so both fields and the frame wrap come around quickly:
//     line 1: F=1 V=1   line 2: F=0 V=1   lines 3-4: F=0 V=0
//     lines 5-6: V=1    lines 7-10: F=1 V=0
module tb_itu656_tx_framer;

  localparam int H_TOTAL  = 1716;
  localparam int H_ACTIVE = 1440;
  localparam int V_TOTAL  = 10;

  logic        clk = 1'b0;
  logic        iRST = 1'b1, iEN = 1'b0, iDVAL = 1'b0;
  logic [15:0] iYCbCr = 16'h0000;
  logic        oRequest, oFIELD, oFRAME_START, oUNDERFLOW;
  logic [7:0]  oTD_DATA;
  logic [9:0]  oLINE;

  int vectors = 0, miscompares = 0;
  int cur_h = 0, cur_line = 1, shown_h = 0, shown_line = 0;
  int word_idx = 0, req_count = 0, mode = 0;

  always #5 clk = ~clk;

  itu656_tx_framer #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL),
    .V1_END(2), .V2_START(5), .V2_END(6), .F0_START(2), .F1_START(6)
  ) dut (
    .iCLK_27(clk), .iRST(iRST), .iEN(iEN), .iYCbCr(iYCbCr), .iDVAL(iDVAL),
    .oRequest(oRequest), .oTD_DATA(oTD_DATA), .oLINE(oLINE), .oFIELD(oFIELD),
    .oFRAME_START(oFRAME_START), .oUNDERFLOW(oUNDERFLOW)
  );

  // Word k of a line: {dval, Y, C}.
  // mode 0: Y=40, C=C0+k.  mode 1: FF/00, 00/FF, a missing word, then Y=55, C=k.
  function automatic logic [16:0] make_word(input int k);
    logic [7:0] kb, c;
    kb = k[7:0];
    c  = 8'hC0 + kb;
    if (mode == 0) return {1'b1, 8'h40, c};
    if (k == 0) return {1'b1, 8'hFF, 8'h00};
    if (k == 1) return {1'b1, 8'h00, 8'hFF};
    if (k == 2) return {1'b0, 8'h12, 8'h34};
    return {1'b1, 8'h55, kb};
  endfunction

  // One clock. The strobe is read mid-cycle; the FIFO word goes out after the
  // edge that ends the strobe cycle. shown_* names the byte now on oTD_DATA.
  task automatic tick();
    logic req_now;
    logic [16:0] w;
    @(negedge clk);
    req_now = oRequest;
    if (req_now) req_count++;
    @(posedge clk);
    #1;
    if (iRST) begin
      cur_h = 0; cur_line = 1; shown_h = 0; shown_line = 0;
    end else if (iEN) begin
      shown_h = cur_h; shown_line = cur_line;
      if (cur_h == H_TOTAL - 1) begin
        cur_h = 0;
        cur_line = (cur_line == V_TOTAL) ? 1 : cur_line + 1;
      end else begin
        cur_h++;
      end
    end
    if (req_now) begin
      w = make_word(word_idx);
      iDVAL = w[16];
      iYCbCr = w[15:0];
      word_idx++;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    iRST = rst;
    iEN  = en;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic runTo(input int ln, input int h);
    int n;
    n = 0;
    while (!(shown_line == ln && shown_h == h) && n < 40000) begin
      tick();
      n++;
    end
    if (n >= 40000) begin
      miscompares++;
      $display("[TB] FAIL run_to line %0d byte %0d observed=timeout expected=reached", ln, h);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] position never reached");
    end
  endtask

  task automatic checkByte(input string tag, input logic [7:0] expected);
    checkOutput(tag, 16'(oTD_DATA), 16'(expected));
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkByte("rst_data", 8'h10);
    checkOutput("rst_request", 16'(oRequest), 16'd0);
    checkOutput("rst_line", 16'(oLINE), 16'd1);
    checkOutput("rst_field", 16'(oFIELD), 16'd1);
    checkOutput("rst_frame_start", 16'(oFRAME_START), 16'd0);
    checkOutput("rst_underflow", 16'(oUNDERFLOW), 16'd0);

    // Line 1: EAV straight after release, frame pulse for one cycle
    applyStimulus(1'b0, 1'b1);
    checkByte("l1_eav0", 8'hFF);
    checkOutput("l1_frame_start", 16'(oFRAME_START), 16'd1);
    tick(); checkByte("l1_eav1", 8'h00);
    checkOutput("l1_frame_start_end", 16'(oFRAME_START), 16'd0);
    tick(); checkByte("l1_eav2", 8'h00);
    tick(); checkByte("l1_eav_xy", 8'hF1);
    tick(); checkByte("l1_blank_even", 8'h80);
    tick(); checkByte("l1_blank_odd", 8'h10);
    runTo(1, 272); checkByte("l1_sav0", 8'hFF);
    tick(); checkByte("l1_sav1", 8'h00);
    tick(); checkByte("l1_sav2", 8'h00);
    tick(); checkByte("l1_sav_xy", 8'hEC);
    tick(); checkByte("l1_vblank_even", 8'h80);
    tick(); checkByte("l1_vblank_odd", 8'h10);

    // No requests on vertical blanking lines
    runTo(2, 0);
    checkOutput("l1_requests", 16'(req_count), 16'd0);
    req_count = 0; word_idx = 0; mode = 0;

    // Line 3: F=0 V=0 codes and a plain pixel ramp
    runTo(3, 3); checkByte("l3_eav_xy", 8'h9D);
    checkOutput("l3_line", 16'(oLINE), 16'd3);
    checkOutput("l3_field", 16'(oFIELD), 16'd0);
    runTo(3, 275); checkByte("l3_sav_xy", 8'h80);
    tick(); checkByte("l3_c0", 8'hC0);
    tick(); checkByte("l3_y0", 8'h40);
    tick(); checkByte("l3_c1", 8'hC1);
    tick(); checkByte("l3_y1", 8'h40);
    runTo(3, 1714); checkByte("l3_c719", 8'h8F);
    tick(); checkByte("l3_y719", 8'h40);
    runTo(4, 0);
    checkOutput("l3_requests", 16'(req_count), 16'd720);
    checkOutput("l3_no_underflow", 16'(oUNDERFLOW), 16'd0);
    word_idx = 0; mode = 1;

    // Line 4: clamp, then one missing word
    runTo(4, 276); checkByte("clamp_c00", 8'h01);
    tick(); checkByte("clamp_yff", 8'hFE);
    tick(); checkByte("clamp_cff", 8'hFE);
    tick(); checkByte("clamp_y00", 8'h01);
    tick(); checkByte("underflow_c", 8'h80);
    checkOutput("underflow_flag", 16'(oUNDERFLOW), 16'd1);
    tick(); checkByte("underflow_y", 8'h10);
    tick(); checkByte("after_underflow_c", 8'h03);
    tick(); checkByte("after_underflow_y", 8'h55);

    // Pause 100 cycles with the counter at 500
    runTo(4, 499);
    applyStimulus(1'b0, 1'b0);
    checkByte("pause_fill_even", 8'h80);
    checkOutput("pause_request", 16'(oRequest), 16'd0);
    applyStimulus(1'b0, 1'b0);
    checkByte("pause_fill_odd", 8'h10);
    for (int i = 0; i < 98; i++) applyStimulus(1'b0, 1'b0);
    checkByte("pause_fill_last", 8'h10);
    checkOutput("pause_line", 16'(oLINE), 16'd4);
    applyStimulus(1'b0, 1'b1);
    checkByte("resume_c112", 8'h70);
    tick(); checkByte("resume_y112", 8'h55);
    tick(); checkByte("resume_c113", 8'h71);

    // Line 7: F=1 V=0 codes
    runTo(7, 3); checkByte("l7_eav_xy", 8'hDA);
    checkOutput("l7_line", 16'(oLINE), 16'd7);
    checkOutput("l7_field", 16'(oFIELD), 16'd1);
    runTo(7, 275); checkByte("l7_sav_xy", 8'hC7);

    // Next frame: pulse again, underflow still held
    runTo(1, 0);
    checkByte("f2_eav0", 8'hFF);
    checkOutput("f2_frame_start", 16'(oFRAME_START), 16'd1);
    checkOutput("f2_line", 16'(oLINE), 16'd1);
    checkOutput("f2_underflow_held", 16'(oUNDERFLOW), 16'd1);

    // Reset in the middle of a line
    runTo(1, 300);
    applyStimulus(1'b1, 1'b1);
    checkByte("midrst_data", 8'h10);
    checkOutput("midrst_line", 16'(oLINE), 16'd1);
    checkOutput("midrst_underflow", 16'(oUNDERFLOW), 16'd0);
    checkOutput("midrst_request", 16'(oRequest), 16'd0);
    applyStimulus(1'b0, 1'b1);
    checkByte("midrst_eav0", 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
